// File: rtl/cpu_gpio_pkg.sv
// ============================================================================
// cpu_gpio_pkg : register offsets and channel stride for the cpu_gpio block
// Revision 1.0
// ============================================================================
`default_nettype none

package cpu_gpio_pkg;

  localparam logic [2:0] REG_OUT  = 3'd0;
  localparam logic [2:0] REG_SET  = 3'd1;
  localparam logic [2:0] REG_CLR  = 3'd2;
  localparam logic [2:0] REG_TGL  = 3'd3;
  localparam logic [2:0] REG_IN   = 3'd4;
  localparam logic [2:0] REG_EN   = 3'd5;
  localparam logic [2:0] REG_STAT = 3'd6;

  localparam int CHAN_STRIDE = 8;

endpackage

`default_nettype wire

// File: rtl/gpio_channel.sv
// ============================================================================
// gpio_channel : one 8-bit port with OUT/EN/STAT, 3-stage input sync, edge irq
// Revision 1.0
// ============================================================================
`default_nettype none

module gpio_channel
  import cpu_gpio_pkg::*;
#(
  parameter logic [7:0] OUT_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we_out,
  input  logic       we_set,
  input  logic       we_clr,
  input  logic       we_tgl,
  input  logic       we_en,
  input  logic       we_stat,
  input  logic [7:0] wdata,
  input  logic [7:0] pins,
  output logic [7:0] out,
  output logic [7:0] in_sync,
  output logic [7:0] en,
  output logic [7:0] stat,
  output logic       chan_irq
);

  logic [7:0] r_out;
  logic [7:0] r_en;
  logic [7:0] r_stat;
  logic [7:0] r_s1;
  logic [7:0] r_s2;
  logic [7:0] r_s3;
  logic [7:0] w_edge;
  logic [7:0] w_w1c;

  assign w_edge = r_s2 & ~r_s3;
  assign w_w1c  = we_stat ? wdata : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out  <= OUT_RESET;
      r_en   <= 8'h00;
      r_stat <= 8'h00;
      r_s1   <= 8'h00;
      r_s2   <= 8'h00;
      r_s3   <= 8'h00;
    end else begin
      r_s1 <= pins;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      // Strobes are mutually exclusive: at most one register offset per write.
      if (we_out)      r_out <= wdata;
      else if (we_set) r_out <= r_out | wdata;
      else if (we_clr) r_out <= r_out & ~wdata;
      else if (we_tgl) r_out <= r_out ^ wdata;
      if (we_en) r_en <= wdata;
      // A fresh edge wins over a simultaneous write-one-to-clear.
      r_stat <= (r_stat & ~w_w1c) | w_edge;
    end
  end

  assign out      = r_out;
  assign in_sync  = r_s2;
  assign en       = r_en;
  assign stat     = r_stat;
  assign chan_irq = |(r_stat & r_en);

endmodule

`default_nettype wire

// File: rtl/cpu_gpio.sv
// ============================================================================
// cpu_gpio : memory-mapped multi-channel GPIO on the 65C02 bus, registered reads
// Revision 1.0
// ============================================================================
`default_nettype none

module cpu_gpio
  import cpu_gpio_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0400,
  parameter int                CHANNELS  = 2,
  parameter logic [7:0]        OUT_RESET = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  we,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic                  hit,
  input  logic [8*CHANNELS-1:0] gpio_in,
  output logic [8*CHANNELS-1:0] gpio_out,
  output logic                  irq
);

  logic [ADDR_W-1:0]   w_off;
  logic                w_in_window;
  logic [2:0]          w_ch;
  logic [2:0]          w_reg;
  logic [7:0]          w_rdata;
  logic [CHANNELS-1:0] w_chan_irq;
  logic [7:0]          w_out  [CHANNELS];
  logic [7:0]          w_in   [CHANNELS];
  logic [7:0]          w_en   [CHANNELS];
  logic [7:0]          w_stat [CHANNELS];
  logic [7:0]          r_data_out;
  logic                r_hit;

  // Offset arithmetic makes unpopulated channel slots fall outside the window.
  assign w_off       = addr - BASE_ADDR;
  assign w_in_window = w_off < ADDR_W'(CHAN_STRIDE * CHANNELS);
  assign w_ch        = w_off[5:3];
  assign w_reg       = addr[2:0];

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      logic w_wr;
      assign w_wr = we && w_in_window && (w_ch == 3'(c));

      gpio_channel #(
        .OUT_RESET (OUT_RESET)
      ) u_chan (
        .clk      (clk),
        .reset    (reset),
        .we_out   (w_wr && (w_reg == REG_OUT)),
        .we_set   (w_wr && (w_reg == REG_SET)),
        .we_clr   (w_wr && (w_reg == REG_CLR)),
        .we_tgl   (w_wr && (w_reg == REG_TGL)),
        .we_en    (w_wr && (w_reg == REG_EN)),
        .we_stat  (w_wr && (w_reg == REG_STAT)),
        .wdata    (data_in),
        .pins     (gpio_in[8*c +: 8]),
        .out      (w_out[c]),
        .in_sync  (w_in[c]),
        .en       (w_en[c]),
        .stat     (w_stat[c]),
        .chan_irq (w_chan_irq[c])
      );

      assign gpio_out[8*c +: 8] = w_out[c];
    end
  endgenerate

  always_comb begin
    w_rdata = 8'h00;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_in_window && (w_ch == 3'(c))) begin
        case (w_reg)
          REG_OUT, REG_SET, REG_CLR, REG_TGL: w_rdata = w_out[c];
          REG_IN:   w_rdata = w_in[c];
          REG_EN:   w_rdata = w_en[c];
          REG_STAT: w_rdata = w_stat[c];
          default:  w_rdata = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= 8'h00;
      r_hit      <= 1'b0;
    end else begin
      r_data_out <= w_rdata;
      r_hit      <= w_in_window;
    end
  end

  assign data_out = r_data_out;
  assign hit      = r_hit;
  assign irq      = |w_chan_irq;

endmodule

`default_nettype wire

// File: tb/tb_cpu_gpio.sv
// ============================================================================
// tb_cpu_gpio : directed self-checking bench for cpu_gpio (two channels)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_cpu_gpio;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        hit;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_gpio #(
    .ADDR_W    (16),
    .BASE_ADDR (16'h0400),
    .CHANNELS  (2),
    .OUT_RESET (8'hA5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .we       (we),
    .data_in  (data_in),
    .data_out (data_out),
    .hit      (hit),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at negedge, return 1 time unit after the rising edge.
  task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic w);
    @(negedge clk);
    addr    = a;
    data_in = d;
    we      = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    addr    = 16'h0000;
    we      = 1'b0;
    data_in = 8'h00;
    gpio_in = 16'h0000;
    cyc(16'h0000, 8'h00, 1'b0);
    cyc(16'h0000, 8'h00, 1'b0);
    check("rst_gpio_out", 32'(gpio_out), 32'h0000A5A5);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_hit", 32'(hit), 32'h0);
    reset = 1'b0;

    cyc(16'h0400, 8'h00, 1'b0);
    check("rd_out0_data", 32'(data_out), 32'hA5);
    check("rd_out0_hit", 32'(hit), 32'h1);

    // OUT / SET / CLR / TGL on channel 0
    cyc(16'h0400, 8'h0F, 1'b1);
    check("wr_out", 32'(gpio_out), 32'h0000A50F);
    cyc(16'h0400, 8'h00, 1'b0);
    check("rd_out", 32'(data_out), 32'h0F);
    cyc(16'h0401, 8'hF0, 1'b1);
    check("wr_set", 32'(gpio_out), 32'h0000A5FF);
    cyc(16'h0401, 8'h00, 1'b0);
    check("rd_set", 32'(data_out), 32'hFF);
    cyc(16'h0402, 8'h3C, 1'b1);
    check("wr_clr", 32'(gpio_out), 32'h0000A5C3);
    cyc(16'h0402, 8'h00, 1'b0);
    check("rd_clr", 32'(data_out), 32'hC3);
    cyc(16'h0403, 8'hFF, 1'b1);
    check("wr_tgl", 32'(gpio_out), 32'h0000A53C);
    cyc(16'h0403, 8'h00, 1'b0);
    check("rd_tgl", 32'(data_out), 32'h3C);

    // Channel 1, out-of-range slot, reserved and IN offsets
    cyc(16'h0408, 8'h55, 1'b1);
    check("wr_ch1_out", 32'(gpio_out), 32'h0000553C);
    cyc(16'h0408, 8'h00, 1'b0);
    check("rd_ch1_out", 32'(data_out), 32'h55);
    cyc(16'h0410, 8'h00, 1'b0);
    check("rd_oor_hit", 32'(hit), 32'h0);
    check("rd_oor_data", 32'(data_out), 32'h00);
    cyc(16'h0410, 8'hFF, 1'b1);
    check("wr_oor_noeffect", 32'(gpio_out), 32'h0000553C);
    cyc(16'h0407, 8'hFF, 1'b1);
    check("wr_rsvd_noeffect", 32'(gpio_out), 32'h0000553C);
    cyc(16'h0407, 8'h00, 1'b0);
    check("rd_rsvd_data", 32'(data_out), 32'h00);
    check("rd_rsvd_hit", 32'(hit), 32'h1);
    cyc(16'h03FF, 8'h00, 1'b0);
    check("rd_below_hit", 32'(hit), 32'h0);

    // Edge latency on pin 0 with EN0=1
    cyc(16'h0405, 8'h01, 1'b1);
    gpio_in = 16'h0001;
    cyc(16'h0404, 8'h00, 1'b0);                 // edge k
    check("in_k", 32'(data_out), 32'h00);
    cyc(16'h0404, 8'h00, 1'b0);                 // edge k+1
    check("irq_k1", 32'(irq), 32'h0);
    cyc(16'h0404, 8'h00, 1'b0);                 // edge k+2
    check("in_k2", 32'(data_out), 32'h01);
    check("irq_k2", 32'(irq), 32'h1);
    cyc(16'h0406, 8'h00, 1'b0);
    check("rd_stat_set", 32'(data_out), 32'h01);
    gpio_in = 16'h0000;
    repeat (4) cyc(16'h0406, 8'h00, 1'b0);
    check("stat_hold_fall", 32'(data_out), 32'h01);
    check("irq_hold_fall", 32'(irq), 32'h1);
    cyc(16'h0406, 8'h01, 1'b1);
    check("w1c_irq", 32'(irq), 32'h0);
    cyc(16'h0406, 8'h00, 1'b0);
    check("w1c_stat", 32'(data_out), 32'h00);

    // Edge and W1C collide on the same edge: set wins
    gpio_in = 16'h0001;
    cyc(16'h0000, 8'h00, 1'b0);
    cyc(16'h0000, 8'h00, 1'b0);
    cyc(16'h0406, 8'h01, 1'b1);
    check("collide_irq", 32'(irq), 32'h1);
    cyc(16'h0406, 8'h00, 1'b0);
    check("collide_stat", 32'(data_out), 32'h01);
    cyc(16'h0406, 8'h01, 1'b1);
    gpio_in = 16'h0000;
    repeat (3) cyc(16'h0000, 8'h00, 1'b0);

    // STAT sets with EN=0; enabling afterwards raises irq on the write edge
    cyc(16'h0405, 8'h00, 1'b1);
    gpio_in = 16'h0002;
    repeat (4) cyc(16'h0406, 8'h00, 1'b0);
    check("en0_irq", 32'(irq), 32'h0);
    check("en0_stat", 32'(data_out), 32'h02);
    cyc(16'h0405, 8'h02, 1'b1);
    check("late_en_irq", 32'(irq), 32'h1);

    // Build STAT=03 then reset during a write
    gpio_in = 16'h0001;
    repeat (4) cyc(16'h0406, 8'h00, 1'b0);
    check("stat_03", 32'(data_out), 32'h03);
    @(negedge clk);
    reset   = 1'b1;
    addr    = 16'h0400;
    data_in = 8'hFF;
    we      = 1'b1;
    @(posedge clk);
    #1;
    check("rstw_gpio_out", 32'(gpio_out), 32'h0000A5A5);
    check("rstw_irq", 32'(irq), 32'h0);
    check("rstw_data_out", 32'(data_out), 32'h00);
    check("rstw_hit", 32'(hit), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cyc(16'h0405, 8'h00, 1'b0);
    check("rstw_en", 32'(data_out), 32'h00);
    cyc(16'h0406, 8'h00, 1'b0);
    check("rstw_stat", 32'(data_out), 32'h00);
    // Pin 0 held high across reset flags exactly one edge afterwards
    repeat (3) cyc(16'h0406, 8'h00, 1'b0);
    check("post_rst_edge", 32'(data_out), 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
